// File: rtl/modn_cascade_counter.sv
// modn_cascade_counter
//   Multi-digit modulo-N up/down counter. Each of DIGITS digits is DW bits wide
//   and counts 0..MODULUS-1. A carry (up) or borrow (down) ripples through the
//   whole chain combinationally, so every digit updates on the same clock edge.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset (beats load and en)
//   en        count enable, one step per edge when high
//   up_dn     direction: 1 = up, 0 = down
//   load      parallel load of load_val (beats en)
//   load_val  load value, digit i at [i*DW +: DW]
//   count     registered count, digit 0 least significant
//   tc        combinational terminal count for cascading a further stage
//   wrap_p    one-cycle pulse after the count wrapped around
//   load_err  one-cycle pulse after a load that contained an out-of-range digit
module modn_cascade_counter #(
  parameter int DIGITS  = 4,
  parameter int DW      = 4,
  parameter int MODULUS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 up_dn,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] count,
  output logic                 tc,
  output logic                 wrap_p,
  output logic                 load_err
);

  localparam logic [DW-1:0] MAX_D   = DW'(MODULUS - 1);
  // One extra bit so MODULUS == 2**DW is representable for the range check.
  localparam logic [DW:0]   MOD_EXT = (DW+1)'(MODULUS);

  logic [DIGITS-1:0]    is_max;
  logic [DIGITS-1:0]    is_zero;
  logic [DIGITS-1:0]    ld_bad;
  logic [DIGITS-1:0]    up_run;
  logic [DIGITS-1:0]    dn_run;
  logic [DIGITS*DW-1:0] up_val;
  logic [DIGITS*DW-1:0] dn_val;
  logic [DIGITS*DW-1:0] load_fix;
  logic                 all_max;
  logic                 all_zero;

  // up_run[i] / dn_run[i]: every digit below i is at its carry / borrow value,
  // so digit i takes part in this step.
  assign up_run[0] = 1'b1;
  assign dn_run[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : gen_digit
      logic [DW-1:0] cur;
      logic [DW-1:0] raw;

      assign cur = count[g*DW +: DW];
      assign raw = load_val[g*DW +: DW];

      assign is_max[g]  = (cur == MAX_D);
      assign is_zero[g] = (cur == '0);

      assign up_val[g*DW +: DW] = up_run[g] ? (is_max[g]  ? '0    : cur + DW'(1)) : cur;
      assign dn_val[g*DW +: DW] = dn_run[g] ? (is_zero[g] ? MAX_D : cur - DW'(1)) : cur;

      // Out-of-range digits are replaced by 0 so a digit never leaves 0..MODULUS-1.
      assign ld_bad[g]            = ({1'b0, raw} >= MOD_EXT);
      assign load_fix[g*DW +: DW] = ld_bad[g] ? '0 : raw;

      if (g < DIGITS - 1) begin : gen_chain
        assign up_run[g+1] = up_run[g] & is_max[g];
        assign dn_run[g+1] = dn_run[g] & is_zero[g];
      end
    end
  endgenerate

  assign all_max  = &is_max;
  assign all_zero = &is_zero;

  // Deliberately not qualified by load or rst; the next stage sees the same
  // load/rst and qualifies its own enable.
  assign tc = en & (up_dn ? all_max : all_zero);

  // Count register plus the two status pulses; rst > load > en.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      wrap_p   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap_p   <= tc & ~load;
      load_err <= load & (|ld_bad);
      if (load) begin
        count <= load_fix;
      end else if (en) begin
        count <= up_dn ? up_val : dn_val;
      end
    end
  end

endmodule

// File: tb/tb_modn_cascade_counter.sv
// Testbench for modn_cascade_counter: a default 4-digit BCD instance and a
// 2-digit, 3-bit, modulo-6 instance. Stimulus tasks push expected responses
// into a scoreboard queue; a monitor pops and compares them on falling edges.
module tb_modn_cascade_counter;

  logic        clk = 1'b0;
  logic        rst, en, up_dn, load;
  logic [15:0] load_val, count;
  logic        tc, wrap_p, load_err;

  logic        rst2, en2, up_dn2, load2;
  logic [5:0]  load_val2, count2;
  logic        tc2, wrap_p2, load_err2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          dut;
    logic [15:0] cnt;
    logic        tc;
    logic        wrap;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  modn_cascade_counter dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .wrap_p(wrap_p),
    .load_err(load_err)
  );

  modn_cascade_counter #(.DIGITS(2), .DW(3), .MODULUS(6)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .up_dn(up_dn2), .load(load2),
    .load_val(load_val2), .count(count2), .tc(tc2), .wrap_p(wrap_p2),
    .load_err(load_err2)
  );

  // Compare one observed value with its expectation and tally the result.
  task automatic checkOutput(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive the default instance for one cycle. The expectation describes what is
  // visible during this cycle: count/wrap_p/load_err from the previous edge and
  // tc from the inputs just driven.
  task automatic applyStimulus(input logic r, input logic e, input logic u, input logic l,
                               input logic [15:0] v, input logic [15:0] ec,
                               input logic et, input logic ew, input logic eer,
                               input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; en = e; up_dn = u; load = l; load_val = v;
    x.dut = 1; x.cnt = ec; x.tc = et; x.wrap = ew; x.err = eer; x.name = nm;
    sb.push_back(x);
  endtask

  // Same for the modulo-6 instance.
  task automatic applyStimulus2(input logic r, input logic e, input logic u, input logic l,
                                input logic [5:0] v, input logic [5:0] ec,
                                input logic et, input logic ew, input logic eer,
                                input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst2 = r; en2 = e; up_dn2 = u; load2 = l; load_val2 = v;
    x.dut = 2; x.cnt = {10'd0, ec}; x.tc = et; x.wrap = ew; x.err = eer; x.name = nm;
    sb.push_back(x);
  endtask

  // Monitor: compare the DUT against each queued expectation mid-cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        if (x.dut == 1) begin
          checkOutput({x.name, " count"},    count,                x.cnt);
          checkOutput({x.name, " tc"},       {15'd0, tc},          {15'd0, x.tc});
          checkOutput({x.name, " wrap_p"},   {15'd0, wrap_p},      {15'd0, x.wrap});
          checkOutput({x.name, " load_err"}, {15'd0, load_err},    {15'd0, x.err});
        end else begin
          checkOutput({x.name, " count"},    {10'd0, count2},      x.cnt);
          checkOutput({x.name, " tc"},       {15'd0, tc2},         {15'd0, x.tc});
          checkOutput({x.name, " wrap_p"},   {15'd0, wrap_p2},     {15'd0, x.wrap});
          checkOutput({x.name, " load_err"}, {15'd0, load_err2},   {15'd0, x.err});
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = '0;
    rst2 = 1'b1; en2 = 1'b0; up_dn2 = 1'b1; load2 = 1'b0; load_val2 = '0;

    // Reset held with en=1, and reset beating a simultaneous load.
    applyStimulus(1, 1, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, "reset0");
    applyStimulus(1, 1, 1, 1, 16'h1234, 16'h0000, 0, 0, 0, "reset1");
    applyStimulus(1, 1, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, "reset2");

    // Ten up steps from zero.
    for (int k = 0; k < 10; k++)
      applyStimulus(0, 1, 1, 0, 16'h0000, 16'(k), 0, 0, 0, "up");
    applyStimulus(0, 0, 1, 0, 16'h0000, 16'h0010, 0, 0, 0, "up10");
    applyStimulus(0, 0, 1, 0, 16'h0000, 16'h0010, 0, 0, 0, "hold");

    // 0099 -> 0100 carry across two digits.
    applyStimulus(0, 0, 1, 1, 16'h0099, 16'h0010, 0, 0, 0, "ld0099");
    applyStimulus(0, 1, 1, 0, 16'h0000, 16'h0099, 0, 0, 0, "step0099");
    applyStimulus(0, 0, 1, 0, 16'h0000, 16'h0100, 0, 0, 0, "is0100");

    // Up wrap 9999 -> 0000 with a single wrap_p pulse (load with en=1 too).
    applyStimulus(0, 1, 1, 1, 16'h9999, 16'h0100, 0, 0, 0, "ld9999");
    applyStimulus(0, 1, 1, 0, 16'h0000, 16'h9999, 1, 0, 0, "upwrap");
    applyStimulus(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, "wrap_pulse");
    applyStimulus(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, "wrap_end");

    // Down wrap 0000 -> 9999, then 1000 -> 0999 borrow.
    applyStimulus(0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, "dnwrap");
    applyStimulus(0, 0, 0, 1, 16'h1000, 16'h9999, 0, 1, 0, "dnwrap_pulse");
    applyStimulus(0, 1, 0, 0, 16'h0000, 16'h1000, 0, 0, 0, "step1000");
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0999, 0, 0, 0, "is0999");

    // Loads: load beats en, invalid digits become 0 and flag load_err.
    applyStimulus(0, 1, 1, 1, 16'h1234, 16'h0999, 0, 0, 0, "ld1234");
    applyStimulus(0, 0, 1, 1, 16'h12A4, 16'h1234, 0, 0, 0, "ld12A4");
    applyStimulus(0, 0, 1, 0, 16'h0000, 16'h1204, 0, 0, 1, "err12A4");
    applyStimulus(0, 0, 1, 1, 16'hF0A3, 16'h1204, 0, 0, 0, "ldF0A3");
    applyStimulus(0, 0, 1, 0, 16'h0000, 16'h0003, 0, 0, 1, "errF0A3");

    // tc not masked by load; a load in the tc cycle gives no wrap_p.
    applyStimulus(0, 0, 1, 1, 16'h9999, 16'h0003, 0, 0, 0, "ld9999b");
    applyStimulus(0, 1, 1, 1, 16'h0457, 16'h9999, 1, 0, 0, "tc_with_load");
    applyStimulus(0, 1, 1, 0, 16'h0000, 16'h0457, 0, 0, 0, "no_wrap_on_load");

    // en toggling from 0457.
    applyStimulus(0, 0, 1, 0, 16'h0000, 16'h0458, 0, 0, 0, "tog0");
    applyStimulus(0, 1, 1, 0, 16'h0000, 16'h0458, 0, 0, 0, "tog1");
    applyStimulus(0, 0, 1, 0, 16'h0000, 16'h0459, 0, 0, 0, "tog2");
    applyStimulus(0, 1, 1, 0, 16'h0000, 16'h0459, 0, 0, 0, "tog3");

    // Load right after a wrap: wrap_p still pulses.
    applyStimulus(0, 1, 1, 1, 16'h9999, 16'h0460, 0, 0, 0, "ld9999c");
    applyStimulus(0, 1, 1, 0, 16'h0000, 16'h9999, 1, 0, 0, "wrap_c");
    applyStimulus(0, 0, 1, 1, 16'h0005, 16'h0000, 0, 1, 0, "load_after_wrap");
    applyStimulus(0, 1, 1, 0, 16'h0000, 16'h0005, 0, 0, 0, "is0005");

    // Mid-run reset, and reset in a tc cycle suppressing wrap_p.
    applyStimulus(1, 1, 1, 0, 16'h0000, 16'h0006, 0, 0, 0, "rst_mid");
    applyStimulus(0, 0, 1, 1, 16'h9999, 16'h0000, 0, 0, 0, "after_rst");
    applyStimulus(1, 1, 1, 0, 16'h0000, 16'h9999, 1, 0, 0, "tc_with_rst");
    applyStimulus(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, "rst_no_wrap");

    // Modulo-6, two 3-bit digits: 00..55 then wrap.
    for (int k = 0; k < 36; k++)
      applyStimulus2(0, 1, 1, 0, 6'o00, 6'(((k / 6) * 8) + (k % 6)), (k == 35), 0, 0, "m6_up");
    applyStimulus2(0, 1, 1, 0, 6'o00, 6'o00, 0, 1, 0, "m6_wrap");
    applyStimulus2(0, 0, 1, 0, 6'o00, 6'o01, 0, 0, 0, "m6_wrap_end");
    applyStimulus2(0, 0, 1, 1, 6'o70, 6'o01, 0, 0, 0, "m6_ld70");
    applyStimulus2(0, 1, 0, 0, 6'o00, 6'o00, 1, 0, 1, "m6_dn");
    applyStimulus2(0, 0, 0, 0, 6'o00, 6'o55, 0, 1, 0, "m6_dnwrap");
    applyStimulus2(0, 0, 0, 0, 6'o00, 6'o55, 0, 0, 0, "m6_hold");

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 20 && sb.size() > 0; i++)
      @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
